serial_injection_arbiter: RTL and testbench
===========================================

// Module: serial_injection_arbiter
// PURPOSE
//   Shares one router local input port among N_REQ serial sources. It grants one source at a time
//   and forwards that source's serial frames to the router port. It arbitrates round-robin at
//   burst granularity and only switches between frames, never mid-frame.
//   Sits between the serial_source instances of a node and the router rx_data/rx_busy local port.
//   Frame format: idle line = 0; start bit = 1, then FLIT_BITS payload bits, MSB first.
// PARAMETERS
//   N_REQ        4   number of requesting sources (2..8)
//   FLIT_BITS    16  payload bits per frame (frame length = FLIT_BITS+1 cycles)
//   MAX_BURST    4   max frames forwarded per grant before rotating
//   ARM_TIMEOUT  16  cycles a granted source may sit without sending a start bit
// PORTS
//   clk          in   1         system clock
//   reset        in   1         synchronous, active-high reset
//   req          in   N_REQ     source i has a frame pending (level, held until sent)
//   req_data     in   N_REQ     serial data line of source i
//   req_busy     out  N_REQ     busy back to source i (1 = do not start a frame)
//   out_data     out  1         serial data to router local rx_data (registered)
//   out_busy     in   1         busy from router local port
//   grant        out  N_REQ     one-hot current owner, 0 when idle
//   stats_grants out  16*N_REQ  per-source grant counters (see CONFIGURATION)
// BEHAVIOUR
//   Reset (sync, any state): state=IDLE, grant=0, req_busy=all 1, out_data=0, burst cnt=0,
//     bit cnt=0, rr pointer=N_REQ-1 (first grant after reset goes to lowest req index >= 0).
//   IDLE: grant=0, req_busy=all 1, out_data<=0. If any req: grant the first set req searching from
//     ptr+1 upward with wrap; ptr<=that index; next state ARM. Grant becomes visible the cycle after req.
//   ARM: req_busy[g]=out_busy (combinational); other busy bits=1; out_data<=req_data[g].
//     req_data[g]==1 -> XFER, bit cnt<=FLIT_BITS. Else req[g]==0 -> IDLE.
//     Else ARM timer reaches ARM_TIMEOUT -> IDLE; timer clears on entering ARM.
//   XFER: out_data<=req_data[g]; req_busy=all 1; bit cnt decrements each cycle.
//     out_busy is ignored in XFER; a started frame always completes.
//   End of frame (cnt==1 -> 0): burst cnt+1. Burst cnt==MAX_BURST or req[g]==0 -> IDLE with
//     burst cnt=0. Otherwise -> ARM, which allows back-to-back frames with zero idle cycles.
//   Latency: out_data = req_data[g] delayed exactly 1 cycle. Frame cycles at out are contiguous.
//   Simultaneous events: a req rising in the same cycle as an end-of-burst is seen next IDLE cycle.
//     Round-robin order is always ptr+1..N_REQ-1, 0..ptr. A lone requester is re-granted after
//     1 IDLE cycle.
//   Only one grant bit may ever be set. Counters wrap nowhere: bit cnt, burst cnt, timer are
//     bounded by the FSM.
//   FSM encoding: IDLE=0, ARM=1, XFER=2; value 3 is illegal and returns to IDLE.
// CONFIGURATION
//   ARB_STATS_EN defined: stats_grants[16*i +: 16] counts IDLE->ARM grants to source i.
//     Counters saturate at 16'hFFFF and are cleared by reset.
//   ARB_STATS_EN undefined: no counter logic is built and stats_grants is tied to 0.
// TESTING
//   1 req=0100 at t0: grant=0100 at t0+1. src2 frame 1+16 bits -> out_data shows the identical 17
//     bits starting 1 cycle later. req drops at the end of the frame -> grant=0 the next cycle.
//   2 req=1111 held, all sources stream frames: grant order 0001,0010,0100,1000,0001. Each grant
//     forwards exactly 4 frames with exactly 1 IDLE cycle between grants.
//   3 req=0001, out_busy=1 held: req_busy[0]=1, no start bit. After 16 ARM cycles -> IDLE; with
//     req=0011, the next grant is 0010.
//   4 out_busy rises mid-XFER: frame completes untouched (17 bits at out). Next ARM holds
//     req_busy[g]=1 until out_busy falls.
//   5 reset asserted at payload bit 5 of a frame from src1: the next cycle grant=0, out_data=0,
//     req_busy=1111. After release with req=1111 the first grant=0001.
//   6 With ARB_STATS_EN, run scenario 2 for 2 full rotations -> stats_grants = 2,2,2,2. Without the
//     macro -> stats_grants = 0.

Source files
------------

// File: rtl/serial_injection_arbiter.sv
// Round-robin, burst-granular arbiter that funnels N_REQ serial frame sources into one router port.
// Define ARB_STATS_EN to build saturating per-source grant counters on stats_grants_o.
module serial_injection_arbiter #(
    parameter int N_REQ       = 4,
    parameter int FLIT_BITS   = 16,
    parameter int MAX_BURST   = 4,
    parameter int ARM_TIMEOUT = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [N_REQ-1:0]     req_data_i,
    output logic [N_REQ-1:0]     req_busy_o,
    output logic                 out_data_o,
    input  logic                 out_busy_i,
    output logic [N_REQ-1:0]     grant_o,
    output logic [16*N_REQ-1:0]  stats_grants_o
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = $clog2(FLIT_BITS + 1);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(ARM_TIMEOUT + 1);

    localparam logic [BW-1:0] BIT_FULL   = BW'(FLIT_BITS);
    localparam logic [BW-1:0] BIT_ONE    = BW'(1);
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(ARM_TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_RESET  = PW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        XFER = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          out_data_q, out_data_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [CW-1:0] burst_q, burst_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [PW-1:0] cand;
    logic [PW-1:0] next_idx;
    logic          found;
    logic          g_req;
    logic          g_data;

    assign g_req      = req_i[ptr_q];
    assign g_data     = req_data_i[ptr_q];
    assign out_data_o = out_data_q;

    // Search starts one past the last owner and wraps, so the last owner has lowest priority.
    always_comb begin
        found    = 1'b0;
        next_idx = ptr_q;
        cand     = ptr_q;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % N_REQ);
            if (!found && req_i[cand]) begin
                found    = 1'b1;
                next_idx = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        out_data_d = 1'b0;
        bit_d      = bit_q;
        burst_d    = burst_q;
        timer_d    = timer_q;
        grant_o    = '0;
        req_busy_o = '1;
        case (state_q)
            IDLE: begin
                bit_d   = '0;
                burst_d = '0;
                timer_d = '0;
                if (found) begin
                    ptr_d   = next_idx;
                    state_d = ARM;
                end
            end
            ARM: begin
                grant_o[ptr_q]    = 1'b1;
                req_busy_o[ptr_q] = out_busy_i;
                out_data_d        = g_data;
                if (g_data) begin
                    state_d = XFER;
                    bit_d   = BIT_FULL;
                end else if (!g_req) begin
                    state_d = IDLE;
                end else if (timer_q == TO_LAST) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            XFER: begin
                // A started frame always runs to completion; out_busy only gates the next start bit.
                grant_o[ptr_q] = 1'b1;
                out_data_d     = g_data;
                bit_d          = bit_q - BW'(1);
                if (bit_q == BIT_ONE) begin
                    if (burst_q == BURST_LAST || !g_req) begin
                        state_d = IDLE;
                        burst_d = '0;
                    end else begin
                        state_d = ARM;
                        burst_d = burst_q + CW'(1);
                        timer_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                bit_d   = '0;
                burst_d = '0;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            ptr_q      <= PTR_RESET;
            out_data_q <= 1'b0;
            bit_q      <= '0;
            burst_q    <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
            bit_q      <= bit_d;
            burst_q    <= burst_d;
            timer_q    <= timer_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stats_q [N_REQ];

    // One count per IDLE->ARM grant, holding at all-ones instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < N_REQ; i++) begin
                stats_q[i] <= '0;
            end
        end else if (state_q == IDLE && found && stats_q[next_idx] != 16'hFFFF) begin
            stats_q[next_idx] <= stats_q[next_idx] + 16'd1;
        end
    end

    always_comb begin
        stats_grants_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            stats_grants_o[16*i +: 16] = stats_q[i];
        end
    end
`else
    assign stats_grants_o = '0;
`endif

endmodule

// File: tb/tb_serial_injection_arbiter.sv
// Randomized bench for serial_injection_arbiter: behavioural sources drive frames, a transaction-level
// reference model predicts grant, busy, serial output and grant statistics every cycle.
module tb_serial_injection_arbiter;

    localparam int N       = 4;
    localparam int FB      = 16;
    localparam int MB      = 4;
    localparam int AT      = 16;
    localparam int CYCLES  = 4000;
    localparam int MID_RST = 2000;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   reqData = '0;
    logic           outBusy = 1'b0;
    logic [N-1:0]   reqBusy;
    logic           outData;
    logic [N-1:0]   grant;
    logic [16*N-1:0] stats;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, whether a frame is in flight, and how far along it is.
    int   mOwner;
    int   mPtr;
    bit   mInFrame;
    int   mBitsLeft;
    int   mArmCycles;
    int   mFrames;
    logic mOut;
    int   mStats [N];

    // Source models.
    int             pend    [N];
    int             pos     [N];
    int             waitCnt [N];
    bit             dropEarly [N];
    logic [FB-1:0]  word    [N];

    serial_injection_arbiter #(
        .N_REQ(N), .FLIT_BITS(FB), .MAX_BURST(MB), .ARM_TIMEOUT(AT)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .req_i(req),
        .req_data_i(reqData),
        .req_busy_o(reqBusy),
        .out_data_o(outData),
        .out_busy_i(outBusy),
        .grant_o(grant),
        .stats_grants_o(stats)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [N-1:0] expGrant();
        logic [N-1:0] g;
        g = '0;
        if (mOwner >= 0) g[2'(mOwner)] = 1'b1;
        return g;
    endfunction

    function automatic logic [N-1:0] expBusy();
        logic [N-1:0] b;
        b = '1;
        if (mOwner >= 0 && !mInFrame) b[2'(mOwner)] = outBusy;
        return b;
    endfunction

    function automatic logic [16*N-1:0] expStats();
        logic [16*N-1:0] s;
        s = '0;
`ifdef ARB_STATS_EN
        for (int i = 0; i < N; i++) s[16*i +: 16] = 16'(mStats[i]);
`endif
        return s;
    endfunction

    function automatic int newWait();
        if ($urandom_range(0, 7) == 0) return 20;
        return int'($urandom_range(0, 2));
    endfunction

    task automatic modelReset();
        mOwner     = -1;
        mPtr       = N - 1;
        mInFrame   = 1'b0;
        mBitsLeft  = 0;
        mArmCycles = 0;
        mFrames    = 0;
        mOut       = 1'b0;
        for (int i = 0; i < N; i++) mStats[i] = 0;
    endtask

    task automatic modelStep();
        logic nextOut;
        int   c;
        nextOut = 1'b0;
        if (mOwner < 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (mPtr + k) % N;
                if (mOwner < 0 && req[c]) begin
                    mOwner     = c;
                    mPtr       = c;
                    mInFrame   = 1'b0;
                    mArmCycles = 0;
                    mFrames    = 0;
                    if (mStats[c] < 65535) mStats[c]++;
                end
            end
        end else begin
            nextOut = reqData[mOwner];
            if (!mInFrame) begin
                if (reqData[mOwner]) begin
                    mInFrame  = 1'b1;
                    mBitsLeft = FB;
                end else if (!req[mOwner]) begin
                    mOwner = -1;
                end else begin
                    mArmCycles++;
                    if (mArmCycles == AT) mOwner = -1;
                end
            end else begin
                mBitsLeft--;
                if (mBitsLeft == 0) begin
                    mInFrame   = 1'b0;
                    mArmCycles = 0;
                    mFrames++;
                    if (mFrames == MB || !req[mOwner]) mOwner = -1;
                end
            end
        end
        mOut = nextOut;
    endtask

    task automatic applyStimulus(input int cycle);
        logic [N-1:0] busyNow;
        bit lastBit;
        reset   = (cycle < 3) || (cycle == MID_RST);
        outBusy = ($urandom_range(0, 3) == 0);
        reqData = '0;
        busyNow = expBusy();
        for (int i = 0; i < N; i++) begin
            if (reset) pos[i] = -1;
            if (pos[i] > 0) begin
                reqData[i] = word[i][4'(FB - pos[i])];
                lastBit    = (pos[i] == FB);
                req[i]     = !(lastBit && pend[i] == 1 && dropEarly[i]);
                if (lastBit) begin
                    pos[i]     = -1;
                    pend[i]    = pend[i] - 1;
                    waitCnt[i] = newWait();
                end else begin
                    pos[i] = pos[i] + 1;
                end
            end else begin
                if (pend[i] == 0 && $urandom_range(0, 5) == 0) pend[i] = int'($urandom_range(1, 6));
                req[i] = (pend[i] > 0);
                if (req[i] && !reset && mOwner == i && !mInFrame) begin
                    if (waitCnt[i] == 0 && !busyNow[i]) begin
                        reqData[i]   = 1'b1;
                        pos[i]       = 1;
                        word[i]      = FB'($urandom);
                        dropEarly[i] = ($urandom_range(0, 1) == 1);
                    end else if (waitCnt[i] > 0) begin
                        waitCnt[i] = waitCnt[i] - 1;
                    end
                end
            end
        end
    endtask

    initial begin
        modelReset();
        for (int i = 0; i < N; i++) begin
            pend[i]      = 0;
            pos[i]       = -1;
            waitCnt[i]   = 0;
            dropEarly[i] = 1'b0;
            word[i]      = '0;
        end
        for (int cycle = 0; cycle < CYCLES; cycle++) begin
            @(negedge clk);
            applyStimulus(cycle);
            #1;
            if (cycle >= 1) begin
                checkOutput("grant", 64'(grant), 64'(expGrant()));
                checkOutput("reqBusy", 64'(reqBusy), 64'(expBusy()));
                checkOutput("outData", 64'(outData), 64'(mOut));
                checkOutput("stats", 64'(stats), 64'(expStats()));
            end
            if (cycle == 3 || cycle == MID_RST + 1) begin
                checkOutput("rstGrant", 64'(grant), 64'(0));
                checkOutput("rstBusy", 64'(reqBusy), 64'(4'hF));
                checkOutput("rstOut", 64'(outData), 64'(0));
            end
            @(posedge clk);
            if (reset) modelReset();
            else modelStep();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
